// File: rtl/ook_packet_decoder.sv
// OOK pulse-width frame decoder: conditions the RF envelope, recovers 16-bit
// frames, checks parity and confirms a command after enough identical repeats.
module ook_packet_decoder #(
   parameter int UNIT_TICKS      = 4800,
   parameter int FILTER_TICKS    = 16,
   parameter int SYNC_UNITS      = 10,
   parameter int BURST_GAP_UNITS = 100,
   parameter int FRAME_BITS      = 16,
   parameter int MIN_REPEATS     = 3,
   parameter int CNT_W           = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ook_in,
   output logic        frame_strobe,
   output logic [11:0] frame_addr,
   output logic [2:0]  frame_cmd,
   output logic        cmd_valid,
   output logic [2:0]  cmd_out,
   output logic [11:0] addr_out,
   output logic        error_strobe,
   output logic        busy
);

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_HIGH, S_LOW, S_CHECK} state_e;

   localparam int FLT_W  = (FILTER_TICKS > 1) ? $clog2(FILTER_TICKS) : 1;
   localparam int BIT_W  = $clog2(FRAME_BITS + 1);
   localparam int REP_W  = $clog2(MIN_REPEATS + 2);
   localparam int DATA_W = FRAME_BITS - 1;

   // Pulse limits are compared against twice the duration so T/2 stays integral.
   localparam logic [CNT_W:0]   LIM_LO     = (CNT_W+1)'(UNIT_TICKS);
   localparam logic [CNT_W:0]   LIM_MID    = (CNT_W+1)'(3 * UNIT_TICKS);
   localparam logic [CNT_W:0]   LIM_HI     = (CNT_W+1)'(5 * UNIT_TICKS);
   localparam logic [CNT_W-1:0] SYNC_TICKS = CNT_W'(SYNC_UNITS * UNIT_TICKS);
   localparam logic [CNT_W-1:0] GAP_TICKS  = CNT_W'(BURST_GAP_UNITS * UNIT_TICKS);

   state_e                  state_q, state_d;
   logic                    meta_q, meta_d;
   logic                    sync_q, sync_d;
   logic                    filt_q, filt_d;
   logic                    filt_prev_q, filt_prev_d;
   logic [FLT_W-1:0]        flt_cnt_q, flt_cnt_d;
   logic [CNT_W-1:0]        dur_q, dur_d;
   logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [REP_W-1:0]        rep_cnt_q, rep_cnt_d;
   logic [DATA_W-1:0]       rep_data_q, rep_data_d;
   logic                    frame_strobe_q, frame_strobe_d;
   logic [11:0]             frame_addr_q, frame_addr_d;
   logic [2:0]              frame_cmd_q, frame_cmd_d;
   logic                    cmd_valid_q, cmd_valid_d;
   logic [2:0]              cmd_out_q, cmd_out_d;
   logic [11:0]             addr_out_q, addr_out_d;
   logic                    error_strobe_q, error_strobe_d;

   logic                    edge_seen, rise, fall;
   logic [CNT_W:0]          dur_x2;
   logic                    pulse_ok, bit_val, too_long;

   // Input conditioning and duration counter
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      meta_d      = ook_in;
      sync_d      = meta_q;
      filt_d      = filt_q;
      flt_cnt_d   = '0;
      filt_prev_d = filt_q;
      if (sync_q != filt_q) begin
         if (flt_cnt_q == FLT_W'(FILTER_TICKS - 1)) filt_d    = sync_q;
         else                                      flt_cnt_d = flt_cnt_q + FLT_W'(1);
      end

      edge_seen = filt_q ^ filt_prev_q;
      rise      = edge_seen & filt_q;
      fall      = edge_seen & ~filt_q;

      // On an edge cycle dur_q still holds the full length of the level that just ended.
      if (edge_seen)         dur_d = CNT_W'(1);
      else if (&dur_q)       dur_d = dur_q;
      else                   dur_d = dur_q + CNT_W'(1);

      dur_x2   = {dur_q, 1'b0};
      pulse_ok = (dur_x2 >= LIM_LO) && (dur_x2 <= LIM_HI);
      bit_val  = (dur_x2 >= LIM_MID);
      too_long = (dur_x2 > LIM_HI);
   end

   // Frame FSM and repeat tracking
   always_comb begin
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      rep_cnt_d      = rep_cnt_q;
      rep_data_d     = rep_data_q;
      frame_strobe_d = 1'b0;
      frame_addr_d   = frame_addr_q;
      frame_cmd_d    = frame_cmd_q;
      cmd_valid_d    = 1'b0;
      cmd_out_d      = cmd_out_q;
      addr_out_d     = addr_out_q;
      error_strobe_d = 1'b0;

      if (!filt_q && (dur_q >= GAP_TICKS)) begin
         rep_cnt_d  = '0;
         rep_data_d = '0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (!filt_q && (dur_q >= SYNC_TICKS)) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (rise) begin
               state_d   = S_HIGH;
               bit_cnt_d = '0;
            end
         end
         S_HIGH: begin
            if (fall) begin
               if (!pulse_ok) begin
                  error_strobe_d = 1'b1;
                  state_d        = S_IDLE;
               end else begin
                  shift_d   = {shift_q[FRAME_BITS-2:0], bit_val};
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  state_d   = (bit_cnt_d == BIT_W'(FRAME_BITS)) ? S_CHECK : S_LOW;
               end
            end else if (too_long) begin
               error_strobe_d = 1'b1;
               state_d        = S_IDLE;
            end
         end
         S_LOW: begin
            // The duration counter keeps running after a timeout so the gap still counts toward arming.
            if (rise) begin
               state_d = S_HIGH;
            end else if (too_long) begin
               error_strobe_d = 1'b1;
               state_d        = S_IDLE;
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
            if (^shift_q == 1'b0) begin
               frame_strobe_d = 1'b1;
               frame_addr_d   = shift_q[FRAME_BITS-1 -: 12];
               frame_cmd_d    = shift_q[3:1];
               if ((rep_cnt_q != '0) && (shift_q[FRAME_BITS-1:1] == rep_data_q)) begin
                  if (!(&rep_cnt_q)) rep_cnt_d = rep_cnt_q + REP_W'(1);
               end else begin
                  rep_cnt_d  = REP_W'(1);
                  rep_data_d = shift_q[FRAME_BITS-1:1];
               end
               if (rep_cnt_d == REP_W'(MIN_REPEATS)) begin
                  cmd_valid_d = 1'b1;
                  cmd_out_d   = frame_cmd_d;
                  addr_out_d  = frame_addr_d;
               end
            end else begin
               error_strobe_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
      if (reset) begin
         state_q        <= S_IDLE;
         meta_q         <= 1'b0;
         sync_q         <= 1'b0;
         filt_q         <= 1'b0;
         filt_prev_q    <= 1'b0;
         flt_cnt_q      <= '0;
         dur_q          <= '0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         rep_cnt_q      <= '0;
         rep_data_q     <= '0;
         frame_strobe_q <= 1'b0;
         frame_addr_q   <= '0;
         frame_cmd_q    <= '0;
         cmd_valid_q    <= 1'b0;
         cmd_out_q      <= '0;
         addr_out_q     <= '0;
         error_strobe_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         meta_q         <= meta_d;
         sync_q         <= sync_d;
         filt_q         <= filt_d;
         filt_prev_q    <= filt_prev_d;
         flt_cnt_q      <= flt_cnt_d;
         dur_q          <= dur_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         rep_cnt_q      <= rep_cnt_d;
         rep_data_q     <= rep_data_d;
         frame_strobe_q <= frame_strobe_d;
         frame_addr_q   <= frame_addr_d;
         frame_cmd_q    <= frame_cmd_d;
         cmd_valid_q    <= cmd_valid_d;
         cmd_out_q      <= cmd_out_d;
         addr_out_q     <= addr_out_d;
         error_strobe_q <= error_strobe_d;
      end
   end

   assign frame_strobe = frame_strobe_q;
   assign frame_addr   = frame_addr_q;
   assign frame_cmd    = frame_cmd_q;
   assign cmd_valid    = cmd_valid_q;
   assign cmd_out      = cmd_out_q;
   assign addr_out     = addr_out_q;
   assign error_strobe = error_strobe_q;
   assign busy         = (state_q == S_HIGH) || (state_q == S_LOW) || (state_q == S_CHECK);

endmodule
